// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry and mret return, one CSR write per cycle, then a redirect pulse
module trap_sequencer #(
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [11:0] CSR_MTVAL   = 12'h343,
    parameter logic [4:0]  EXCEPT_NONE = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  trapID,
    input  logic [31:0] pc_MEM,
    input  logic [31:0] faulting_inst_i,
    input  logic [31:0] faulting_va_IMEM_i,
    input  logic [31:0] faulting_va_DMEM_i,
    input  logic        dmem_fault_i,
    input  logic        mret_MEM,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mstatus_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        csr_branch_signal,
    output logic [31:0] csr_branch_target,
    output logic        trap_busy
);
    typedef enum logic [2:0] {IDLE, WR_EPC, WR_CAUSE, WR_TVAL, WR_STATUS, MRET_STATUS, REDIRECT} state_t;

    state_t      state, state_nxt;
    logic [31:0] epc, cause, tval, tgt_q, tval_cap, redirect_pc;
    logic        mret_q, trap_req;

    assign trap_req    = trapID != EXCEPT_NONE;
    assign redirect_pc = (mret_q ? mepc_i : mtvec_i) & ~32'h3;

    // Trap value selected by exception code: instruction bits, faulting VA, or zero
    always_comb begin
        tval_cap = (trapID == 5'd2) ? faulting_inst_i :
                   (trapID == 5'd12 || trapID == 5'd13 || trapID == 5'd15) ?
                       (dmem_fault_i ? faulting_va_DMEM_i : faulting_va_IMEM_i) :
                   (trapID == 5'd0) ? faulting_va_IMEM_i : 32'd0;
    end

    // State register plus capture of trap context on acceptance and of the redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            epc    <= '0;
            cause  <= '0;
            tval   <= '0;
            tgt_q  <= '0;
            mret_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && trap_req) begin
                epc    <= pc_MEM & ~32'h3;
                cause  <= {27'd0, trapID};
                tval   <= tval_cap;
                mret_q <= 1'b0;
            end else if (state == IDLE && mret_MEM) begin
                mret_q <= 1'b1;
            end
            if (state == REDIRECT)
                tgt_q <= redirect_pc;
        end
    end

    // Next state and per-state CSR write / redirect outputs; trap beats mret in IDLE
    always_comb begin
        state_nxt         = state;
        csr_we_o          = 1'b0;
        csr_waddr_o       = '0;
        csr_wdata_o       = '0;
        csr_branch_signal = 1'b0;
        csr_branch_target = tgt_q;
        trap_busy         = state != IDLE;
        case (state)
            IDLE:        state_nxt = trap_req ? WR_EPC : (mret_MEM ? MRET_STATUS : IDLE);
            WR_EPC: begin
                state_nxt   = WR_CAUSE;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc;
            end
            WR_CAUSE: begin
                state_nxt   = WR_TVAL;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause;
            end
            WR_TVAL: begin
                state_nxt   = WR_STATUS;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = tval;
            end
            WR_STATUS: begin
                state_nxt   = REDIRECT;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:13], 2'b11, mstatus_i[10:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
            end
            MRET_STATUS: begin
                state_nxt   = REDIRECT;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:13], 2'b11, mstatus_i[10:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
            end
            REDIRECT: begin
                state_nxt         = IDLE;
                csr_branch_signal = 1'b1;
                csr_branch_target = redirect_pc;
            end
            default:     state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed checks of trap entry, mret, priority, busy-ignore and mid-sequence reset
module tb_trap_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  trapID = 5'd31;
    logic [31:0] pc_MEM = '0, faulting_inst_i = '0, faulting_va_IMEM_i = '0, faulting_va_DMEM_i = '0;
    logic        dmem_fault_i = 1'b0, mret_MEM = 1'b0;
    logic [31:0] mtvec_i = '0, mepc_i = '0, mstatus_i = '0;
    logic        csr_we_o, csr_branch_signal, trap_busy;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, csr_branch_target;

    int n_cmp = 0, n_err = 0;
    logic [11:0] ea [4];
    logic [31:0] ed [4];

    trap_sequencer dut (
        .clk(clk), .rst(rst), .trapID(trapID), .pc_MEM(pc_MEM),
        .faulting_inst_i(faulting_inst_i), .faulting_va_IMEM_i(faulting_va_IMEM_i),
        .faulting_va_DMEM_i(faulting_va_DMEM_i), .dmem_fault_i(dmem_fault_i),
        .mret_MEM(mret_MEM), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .csr_branch_signal(csr_branch_signal), .csr_branch_target(csr_branch_target),
        .trap_busy(trap_busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({csr_we_o, csr_waddr_o, csr_wdata_o, csr_branch_signal, csr_branch_target, trap_busy} !== 78'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got we=%b a=%h d=%h br=%b t=%h busy=%b, want all 0",
                     csr_we_o, csr_waddr_o, csr_wdata_o, csr_branch_signal, csr_branch_target, trap_busy);
        end
        cyc();
        rst = 1'b1;
        cyc();
        #4;
        n_cmp++;
        if ({csr_we_o, csr_branch_signal, trap_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got we=%b br=%b busy=%b, want 000", csr_we_o, csr_branch_signal, trap_busy);
        end
    endtask

    task automatic test_illegal_inst();
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{32'h0000_1008, 32'd2, 32'hFFFF_FFFF, 32'h0000_1880};
        trapID = 5'd2; pc_MEM = 32'h0000_1008; faulting_inst_i = 32'hFFFF_FFFF;
        mtvec_i = 32'h0000_0101; mstatus_i = 32'h0000_0008;
        #4;
        n_cmp++;
        if (trap_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ill_pre_busy: got %b want 0", trap_busy);
        end
        cyc();
        trapID = 5'd31;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_cmp++;
            if ({csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy, csr_branch_signal} !== {1'b1, ea[i], ed[i], 2'b10}) begin
                n_err++;
                $display("FAIL ill_write%0d: got we=%b a=%h d=%h busy=%b br=%b want we=1 a=%h d=%h busy=1 br=0",
                         i, csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy, csr_branch_signal, ea[i], ed[i]);
            end
            cyc();
        end
        #4;
        n_cmp++;
        if ({csr_we_o, csr_branch_signal, csr_branch_target, trap_busy} !== {2'b01, 32'h0000_0100, 1'b1}) begin
            n_err++;
            $display("FAIL ill_redirect: got we=%b br=%b t=%h busy=%b want we=0 br=1 t=00000100 busy=1",
                     csr_we_o, csr_branch_signal, csr_branch_target, trap_busy);
        end
        cyc();
        #4;
        n_cmp++;
        if ({csr_we_o, csr_branch_signal, csr_branch_target, trap_busy} !== {2'b00, 32'h0000_0100, 1'b0}) begin
            n_err++;
            $display("FAIL ill_after: got we=%b br=%b t=%h busy=%b want we=0 br=0 t=00000100 busy=0",
                     csr_we_o, csr_branch_signal, csr_branch_target, trap_busy);
        end
    endtask

    task automatic test_dmem_page_fault();
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{32'h0000_2000, 32'd13, 32'hDEAD_B000, 32'h0000_1800};
        cyc();
        trapID = 5'd13; dmem_fault_i = 1'b1; faulting_va_DMEM_i = 32'hDEAD_B000;
        faulting_va_IMEM_i = 32'h1111_1111; faulting_inst_i = 32'h2222_2222;
        pc_MEM = 32'h0000_2000; mstatus_i = 32'h0; mtvec_i = 32'h0000_0200;
        cyc();
        trapID = 5'd31; dmem_fault_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_cmp++;
            if ({csr_we_o, csr_waddr_o, csr_wdata_o} !== {1'b1, ea[i], ed[i]}) begin
                n_err++;
                $display("FAIL dpf_write%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                         i, csr_we_o, csr_waddr_o, csr_wdata_o, ea[i], ed[i]);
            end
            cyc();
        end
        #4;
        n_cmp++;
        if ({csr_branch_signal, csr_branch_target} !== {1'b1, 32'h0000_0200}) begin
            n_err++;
            $display("FAIL dpf_redirect: got br=%b t=%h want br=1 t=00000200", csr_branch_signal, csr_branch_target);
        end
        cyc();
    endtask

    task automatic test_mret();
        cyc();
        mret_MEM = 1'b1; mstatus_i = 32'h0000_1880; mepc_i = 32'h0000_100C; mtvec_i = 32'h0000_0400;
        cyc();
        mret_MEM = 1'b0;
        #4;
        n_cmp++;
        if ({csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy, csr_branch_signal} !== {1'b1, 12'h300, 32'h0000_1888, 2'b10}) begin
            n_err++;
            $display("FAIL mret_write: got we=%b a=%h d=%h busy=%b br=%b want we=1 a=300 d=00001888 busy=1 br=0",
                     csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy, csr_branch_signal);
        end
        cyc();
        #4;
        n_cmp++;
        if ({csr_we_o, csr_branch_signal, csr_branch_target, trap_busy} !== {2'b01, 32'h0000_100C, 1'b1}) begin
            n_err++;
            $display("FAIL mret_redirect: got we=%b br=%b t=%h busy=%b want we=0 br=1 t=0000100c busy=1",
                     csr_we_o, csr_branch_signal, csr_branch_target, trap_busy);
        end
        cyc();
        #4;
        n_cmp++;
        if ({csr_branch_signal, csr_branch_target, trap_busy} !== {1'b0, 32'h0000_100C, 1'b0}) begin
            n_err++;
            $display("FAIL mret_after: got br=%b t=%h busy=%b want br=0 t=0000100c busy=0",
                     csr_branch_signal, csr_branch_target, trap_busy);
        end
    endtask

    task automatic test_simultaneous();
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{32'h0000_3000, 32'd12, 32'hCAFE_0000, 32'h0000_1880};
        cyc();
        trapID = 5'd12; mret_MEM = 1'b1; dmem_fault_i = 1'b0; faulting_va_IMEM_i = 32'hCAFE_0000;
        faulting_va_DMEM_i = 32'h3333_3333; pc_MEM = 32'h0000_3003; mstatus_i = 32'h0000_0088;
        mtvec_i = 32'h0000_0303; mepc_i = 32'h0000_7770;
        cyc();
        trapID = 5'd31; mret_MEM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_cmp++;
            if ({csr_we_o, csr_waddr_o, csr_wdata_o} !== {1'b1, ea[i], ed[i]}) begin
                n_err++;
                $display("FAIL sim_write%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                         i, csr_we_o, csr_waddr_o, csr_wdata_o, ea[i], ed[i]);
            end
            cyc();
        end
        #4;
        n_cmp++;
        if ({csr_branch_signal, csr_branch_target} !== {1'b1, 32'h0000_0300}) begin
            n_err++;
            $display("FAIL sim_redirect: got br=%b t=%h want br=1 t=00000300", csr_branch_signal, csr_branch_target);
        end
        cyc();
        #4;
        n_cmp++;
        if ({csr_we_o, trap_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL sim_no_mret: got we=%b busy=%b want 0 0", csr_we_o, trap_busy);
        end
    endtask

    task automatic test_back_to_back();
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{32'h0000_4000, 32'd2, 32'h1234_5678, 32'h0000_1800};
        cyc();
        trapID = 5'd2; pc_MEM = 32'h0000_4000; faulting_inst_i = 32'h1234_5678;
        mstatus_i = 32'h0; mtvec_i = 32'h0000_0400;
        cyc();
        trapID = 5'd31;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_cmp++;
            if ({csr_we_o, csr_waddr_o, csr_wdata_o} !== {1'b1, ea[i], ed[i]}) begin
                n_err++;
                $display("FAIL b2b_write%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                         i, csr_we_o, csr_waddr_o, csr_wdata_o, ea[i], ed[i]);
            end
            if (i == 1) begin
                trapID = 5'd2; mret_MEM = 1'b1; pc_MEM = 32'h0000_5004;
            end
            cyc();
        end
        #4;
        n_cmp++;
        if ({csr_branch_signal, csr_branch_target, trap_busy} !== {1'b1, 32'h0000_0400, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_redirect: got br=%b t=%h busy=%b want br=1 t=00000400 busy=1",
                     csr_branch_signal, csr_branch_target, trap_busy);
        end
        cyc();
        #4;
        n_cmp++;
        if ({csr_we_o, csr_branch_signal, trap_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL b2b_idle: got we=%b br=%b busy=%b want 000", csr_we_o, csr_branch_signal, trap_busy);
        end
        cyc();
        trapID = 5'd31; mret_MEM = 1'b0;
        #4;
        n_cmp++;
        if ({csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy} !== {1'b1, 12'h341, 32'h0000_5004, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_second: got we=%b a=%h d=%h busy=%b want we=1 a=341 d=00005004 busy=1",
                     csr_we_o, csr_waddr_o, csr_wdata_o, trap_busy);
        end
        repeat (5) cyc();
        #4;
        n_cmp++;
        if (trap_busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done: got busy=%b want 0", trap_busy);
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        trapID = 5'd0; pc_MEM = 32'h0000_5000; faulting_va_IMEM_i = 32'h0000_5002;
        mstatus_i = 32'h0; mtvec_i = 32'h0000_0500;
        cyc();
        trapID = 5'd31;
        cyc();
        cyc();
        #4;
        n_cmp++;
        if ({csr_we_o, csr_waddr_o, csr_wdata_o} !== {1'b1, 12'h343, 32'h0000_5002}) begin
            n_err++;
            $display("FAIL rst_tval: got we=%b a=%h d=%h want we=1 a=343 d=00005002", csr_we_o, csr_waddr_o, csr_wdata_o);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({csr_we_o, csr_waddr_o, csr_wdata_o, csr_branch_signal, csr_branch_target, trap_busy} !== 78'd0) begin
            n_err++;
            $display("FAIL rst_async: got we=%b a=%h d=%h br=%b t=%h busy=%b want all 0",
                     csr_we_o, csr_waddr_o, csr_wdata_o, csr_branch_signal, csr_branch_target, trap_busy);
        end
        cyc();
        #2;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            #4;
            n_cmp++;
            if ({csr_we_o, csr_branch_signal, csr_branch_target, trap_busy} !== 35'd0) begin
                n_err++;
                $display("FAIL rst_quiet%0d: got we=%b br=%b t=%h busy=%b want all 0",
                         i, csr_we_o, csr_branch_signal, csr_branch_target, trap_busy);
            end
        end
        cyc();
        trapID = 5'd2; faulting_inst_i = 32'h0000_0013; pc_MEM = 32'h0000_6000;
        cyc();
        trapID = 5'd31;
        #4;
        n_cmp++;
        if ({csr_we_o, csr_waddr_o, csr_wdata_o} !== {1'b1, 12'h341, 32'h0000_6000}) begin
            n_err++;
            $display("FAIL rst_next_trap: got we=%b a=%h d=%h want we=1 a=341 d=00006000", csr_we_o, csr_waddr_o, csr_wdata_o);
        end
        repeat (6) cyc();
    endtask

    initial begin
        test_reset();
        test_illegal_inst();
        test_dmem_page_fault();
        test_mret();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Downstream consumer of the hazard unit's exception outputs (trapID, faulting_inst_o, faulting_va_IMEM_o). Performs machine-mode trap entry and mret return.
- Sequences CSR updates (mepc, mcause, mtval, mstatus) one per cycle over a single CSR write port.
- Then pulses csr_branch_signal with the redirect target. That signal feeds back into the hazard unit as a FLUSH_ALL source.
- Holds trap_busy high for the whole sequence; the front end stalls on it.

Parameters:
- CSR_MSTATUS, 12'h300, mstatus address
- CSR_MEPC, 12'h341, mepc address
- CSR_MCAUSE, 12'h342, mcause address
- CSR_MTVAL, 12'h343, mtval address
- EXCEPT_NONE, 5'd31, trapID code meaning no trap (EXCEPT_DO_NOTHING); every other trapID value is the mcause exception code

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- trapID  in  5  trap code from hazard unit
- pc_MEM  in  32  PC of instruction in MEM
- faulting_inst_i  in  32  faulting instruction bits
- faulting_va_IMEM_i  in  32  IMEM-side faulting VA
- faulting_va_DMEM_i  in  32  DMEM-side faulting VA
- dmem_fault_i  in  1  current fault originates from DMEM
- mret_MEM  in  1  mret retiring in MEM
- mtvec_i  in  32  current mtvec
- mepc_i  in  32  current mepc
- mstatus_i  in  32  current mstatus
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data
- csr_branch_signal  out  1  one-cycle redirect pulse
- csr_branch_target  out  32  redirect PC
- trap_busy  out  1  sequence in progress, stall fetch

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. Capture registers cleared.
- States: IDLE, WR_EPC, WR_CAUSE, WR_TVAL, WR_STATUS, MRET_STATUS, REDIRECT.
- IDLE, on trapID!=EXCEPT_NONE at a clock edge:
  - Capture epc={pc_MEM[31:2],2'b00} and cause={27'b0,trapID}.
  - Capture tval per code:
    - 2 (illegal inst): faulting_inst_i
    - 12/13/15 (page fault): dmem_fault_i ? faulting_va_DMEM_i : faulting_va_IMEM_i
    - 0 (misaligned PC): faulting_va_IMEM_i
    - otherwise: 0
  - Next state WR_EPC.
- IDLE, on mret_MEM=1 with no trap: next state MRET_STATUS.
- Trap and mret in the same cycle: trap wins, mret is dropped.
- Write states: exactly one CSR write per cycle, csr_we_o=1.
  - WR_EPC writes mepc=epc.
  - WR_CAUSE writes mcause=cause.
  - WR_TVAL writes mtval=tval.
  - WR_STATUS writes mstatus_i with MPIE[7]=mstatus_i[3], MIE[3]=0, MPP[12:11]=2'b11.
  - MRET_STATUS writes mstatus_i with MIE[3]=mstatus_i[7], MPIE[7]=1, MPP=2'b11.
  - csr_we_o is 0 in all other states.
- REDIRECT: csr_branch_signal=1 for exactly one cycle, then next state IDLE.
  - Trap path: target={mtvec_i[31:2],2'b00}. Mode bits are ignored; exceptions only.
  - mret path: target={mepc_i[31:2],2'b00}.
  - mtvec_i and mepc_i are sampled in the REDIRECT cycle, after all writes have landed.
- trap_busy=1 in every non-IDLE state, including REDIRECT.
- Latency:
  - Trap detected at edge E: writes on cycles E+1..E+4, redirect pulse on E+5. Busy lasts 5 cycles.
  - mret: write on E+1, redirect on E+2.
- While non-IDLE, trapID and mret_MEM are ignored; the pipeline is flushed/bubbled. A trap is accepted again only when back in IDLE.
- Back-to-back: a trap presented in the cycle after REDIRECT is accepted normally.
- Reset mid-sequence: immediate return to IDLE, all outputs 0. CSR writes already issued are not rolled back.
- csr_branch_target holds its last value outside REDIRECT. It is reset to 0.

Test Plan:
- Illegal inst: trapID=2, pc_MEM=32'h0000_1008, faulting_inst_i=32'hFFFF_FFFF, mtvec_i=32'h0000_0101, mstatus_i=32'h0000_0008 -> writes 341<=1008, 342<=2, 343<=FFFFFFFF, 300<=00001880 on consecutive cycles; target 00000100 with one-cycle pulse; busy 5 cycles.
- DMEM load page fault: trapID=13, dmem_fault_i=1, faulting_va_DMEM_i=32'hDEAD_B000 -> mtval<=DEADB000, mcause<=13.
- mret: mret_MEM=1, mstatus_i=32'h0000_1880, mepc_i=32'h0000_100C -> 300<=00001888, target 0000100C at E+2, busy 2 cycles.
- Simultaneous trapID=12 and mret_MEM=1 -> trap sequence only; no MRET_STATUS write.
- trapID=2 asserted again during WR_CAUSE -> ignored, no restart; new trap accepted only after the REDIRECT cycle.
- rst low during WR_TVAL -> all outputs 0 immediately; after release, idle with no pulse until the next trapID.
